// File: rtl/speech_phone_queue.sv
// speech_phone_queue: CPU-to-speech-chip phone FIFO with a launch/duration
// sequencer timed by an internal clock-enable divider, plus the AR ready line.
// Optional build macro SPEECH_PHONE_QUEUE_FLUSH_EN adds a 'flush' input that
// empties the queue and launches a single STOP_CODE phone.
module speech_phone_queue #(
    parameter int                 PHONE_W   = 6,
    parameter int                 INFL_W    = 2,
    parameter int                 DEPTH     = 8,
    parameter int                 CLK_DIV   = 69,
    parameter int                 DUR_W     = 8,
    parameter int                 AR_MODE   = 0,
    parameter logic [PHONE_W-1:0] STOP_CODE = 6'h3F
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         cpu_we,
    input  logic [PHONE_W+INFL_W-1:0]    cpu_din,
    input  logic [DUR_W-1:0]             dur_in,
`ifdef SPEECH_PHONE_QUEUE_FLUSH_EN
    input  logic                         flush,
`endif
    output logic [PHONE_W-1:0]           phone_out,
    output logic [INFL_W-1:0]            infl_out,
    output logic                         phone_stb,
    output logic                         busy,
    output logic                         ar,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    input  logic                         ovf_clr
);

    localparam int DATA_W = PHONE_W + INFL_W;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W  = $clog2(DEPTH + 1);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_LOAD,
        S_PLAY,
        S_DONE,
        S_STOP
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic [PHONE_W-1:0]  phone_q, phone_d;
    logic [INFL_W-1:0]   infl_q, infl_d;
    logic                stb_q, stb_d;
    logic                ar_q, ar_d;
    logic                ovf_q, ovf_d;

    logic                flushReq;
    logic                isEmpty;
    logic                isFull;
    logic                tick;
    logic                popEn;
    logic                pushEn;
    logic                dropWr;
    logic [DATA_W-1:0]   headData;

`ifdef SPEECH_PHONE_QUEUE_FLUSH_EN
    assign flushReq = flush;
`else
    assign flushReq = 1'b0;
`endif

    assign isEmpty  = (level_q == '0);
    assign isFull   = (level_q == LVL_FULL);
    assign tick     = (div_q == DIV_LAST);
    assign headData = mem_q[rd_ptr_q];

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer next state: launch whenever the queue holds a phone, play out the latched duration, chain back-to-back from DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (!isEmpty) state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_LOAD;
            S_LOAD:   state_d = S_PLAY;
            S_PLAY:   if (tick && (dur_q <= DUR_ONE)) state_d = S_DONE;
            S_DONE:   state_d = isEmpty ? S_IDLE : S_LAUNCH;
            S_STOP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (flushReq) begin
            state_d = S_STOP;
        end
    end

    // Sequencer outputs and FIFO bookkeeping: pop only on entry to LAUNCH, a full-queue write survives only when that pop frees a slot.
    always_comb begin
        popEn    = (state_d == S_LAUNCH);
        pushEn   = cpu_we && !flushReq && (!isFull || popEn);
        dropWr   = cpu_we && !flushReq && isFull && !popEn;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flushReq) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (pushEn) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (popEn)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (pushEn && !popEn) begin
                level_d = level_q + LVL_ONE;
            end else if (popEn && !pushEn) begin
                level_d = level_q - LVL_ONE;
            end
        end

        phone_d = phone_q;
        infl_d  = infl_q;
        if (popEn) begin
            phone_d = headData[PHONE_W-1:0];
            infl_d  = headData[DATA_W-1:PHONE_W];
        end else if (flushReq) begin
            phone_d = STOP_CODE;
            infl_d  = '0;
        end
        stb_d = popEn || flushReq;

        if ((state_q == S_LAUNCH) || tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_ONE;
        end

        dur_d = dur_q;
        if (state_q == S_LOAD) begin
            dur_d = (dur_in == '0) ? DUR_ONE : dur_in;
        end else if ((state_q == S_PLAY) && tick) begin
            dur_d = dur_q - DUR_ONE;
        end

        if (AR_MODE == 1) begin
            ar_d = (level_q != LVL_FULL);
        end else begin
            ar_d = isEmpty && (state_q == S_IDLE);
        end

        if (ovf_clr) begin
            ovf_d = 1'b0;
        end else if (dropWr) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Datapath registers: pointers, occupancy, divider, duration counter and the registered chip-side outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            div_q    <= '0;
            dur_q    <= '0;
            phone_q  <= STOP_CODE;
            infl_q   <= '0;
            stb_q    <= 1'b0;
            ar_q     <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            div_q    <= div_d;
            dur_q    <= dur_d;
            phone_q  <= phone_d;
            infl_q   <= infl_d;
            stb_q    <= stb_d;
            ar_q     <= ar_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            mem_q[wr_ptr_q] <= cpu_din;
        end
    end

    assign phone_out = phone_q;
    assign infl_out  = infl_q;
    assign phone_stb = stb_q;
    assign busy      = (state_q != S_IDLE);
    assign ar        = ar_q;
    assign level     = level_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_speech_phone_queue.sv
// tb_speech_phone_queue: table-driven, directed and randomized checks of
// speech_phone_queue against a queue/timeline reference model. Two instances
// share the stimulus so both AR modes are observed at once.
module tb_speech_phone_queue;

    localparam int         DEPTH   = 8;
    localparam int         CLK_DIV = 4;
    localparam logic [5:0] STOP    = 6'h3F;

    typedef struct {
        bit          we;
        logic [7:0]  din;
        logic [7:0]  dur;
        bit          stb;
        bit          busy;
        logic [5:0]  phone;
        logic [1:0]  infl;
        bit          ar;
        logic [3:0]  lvl;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        cpuWe;
    logic        ovfClr;
    logic [7:0]  cpuDin;
    logic [7:0]  durIn;
`ifdef SPEECH_PHONE_QUEUE_FLUSH_EN
    logic        flushIn;
`endif

    logic [5:0]  phone0, phone1;
    logic [1:0]  infl0, infl1;
    logic        stb0, stb1, busy0, busy1, ar0, ar1, ovf0, ovf1;
    logic [3:0]  level0, level1;

    // reference model state
    logic [7:0]  mq[$];
    bit          mBusy, mStop, mStb, mAr0, mAr1, mOvf;
    int          mT, mEnd;
    logic [5:0]  mPhone;
    logic [1:0]  mInfl;

    int          nVec, nBad, cycleNo;
    int          stbCyc[$];
    logic [5:0]  stbPhone[$];
    logic [3:0]  stbLevel[$];
    vec_t        tbl[17];

    speech_phone_queue #(
        .PHONE_W(6), .INFL_W(2), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV),
        .DUR_W(8), .AR_MODE(0), .STOP_CODE(6'h3F)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .cpu_we(cpuWe), .cpu_din(cpuDin), .dur_in(durIn),
`ifdef SPEECH_PHONE_QUEUE_FLUSH_EN
        .flush(flushIn),
`endif
        .phone_out(phone0), .infl_out(infl0), .phone_stb(stb0), .busy(busy0),
        .ar(ar0), .level(level0), .overflow(ovf0), .ovf_clr(ovfClr)
    );

    speech_phone_queue #(
        .PHONE_W(6), .INFL_W(2), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV),
        .DUR_W(8), .AR_MODE(1), .STOP_CODE(6'h3F)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .cpu_we(cpuWe), .cpu_din(cpuDin), .dur_in(durIn),
`ifdef SPEECH_PHONE_QUEUE_FLUSH_EN
        .flush(flushIn),
`endif
        .phone_out(phone1), .infl_out(infl1), .phone_stb(stb1), .busy(busy1),
        .ar(ar1), .level(level1), .overflow(ovf1), .ovf_clr(ovfClr)
    );

    // 100 MHz-style free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something never settles
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nBad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mBusy  = 1'b0;
        mStop  = 1'b0;
        mStb   = 1'b0;
        mAr0   = 1'b1;
        mAr1   = 1'b1;
        mOvf   = 1'b0;
        mT     = 0;
        mEnd   = 0;
        mPhone = STOP;
        mInfl  = 2'd0;
    endtask

    // One clock of the behavioural model: a phone occupies strobe..DONE,
    // which is 1 + dur*CLK_DIV cycles after its strobe.
    task automatic modelStep();
        int         sz;
        bit         fl;
        bit         launch;
        bit         pushOk;
        int         d;
        logic [7:0] head;
        sz = mq.size();
`ifdef SPEECH_PHONE_QUEUE_FLUSH_EN
        fl = flushIn;
`else
        fl = 1'b0;
`endif
        launch = !fl && (sz > 0) && (!mBusy || (!mStop && (mT == mEnd)));
        pushOk = cpuWe && !fl && ((sz < DEPTH) || launch);
        if (ovfClr) mOvf = 1'b0;
        else if (cpuWe && !fl && (sz == DEPTH) && !launch) mOvf = 1'b1;
        mAr0 = (sz == 0) && !mBusy;
        mAr1 = (sz != DEPTH);
        if (fl) begin
            mq.delete();
            mBusy  = 1'b1;
            mStop  = 1'b1;
            mStb   = 1'b1;
            mPhone = STOP;
            mInfl  = 2'd0;
        end else if (launch) begin
            head   = mq.pop_front();
            mPhone = head[5:0];
            mInfl  = head[7:6];
            mBusy  = 1'b1;
            mStop  = 1'b0;
            mStb   = 1'b1;
            mT     = 0;
            mEnd   = 1000000;
        end else begin
            mStb = 1'b0;
            if (mBusy) begin
                if (mStop || (mT == mEnd)) begin
                    mBusy = 1'b0;
                    mStop = 1'b0;
                end else begin
                    if (mT == 1) begin
                        d    = (durIn == 8'd0) ? 1 : int'(durIn);
                        mEnd = 1 + d * CLK_DIV;
                    end
                    mT++;
                end
            end
        end
        if (pushOk) mq.push_back(cpuDin);
    endtask

    task automatic checkOutput();
        check("phone", phone0, mPhone);
        check("infl", infl0, mInfl);
        check("stb", stb0, mStb);
        check("busy", busy0, mBusy);
        check("level", level0, mq.size());
        check("overflow", ovf0, mOvf);
        check("ar_mode0", ar0, mAr0);
        check("ar_mode1", ar1, mAr1);
        check("mode1_other", {phone1, infl1, stb1, busy1, level1, ovf1},
              {mPhone, mInfl, mStb, mBusy, 4'(mq.size()), mOvf});
    endtask

    task automatic applyStimulus(input logic we, input logic [7:0] din, input logic clr);
        cpuWe  = we;
        cpuDin = din;
        ovfClr = clr;
        @(posedge clk);
        modelStep();
        #1;
        cpuWe  = 1'b0;
        ovfClr = 1'b0;
`ifdef SPEECH_PHONE_QUEUE_FLUSH_EN
        flushIn = 1'b0;
`endif
        cycleNo++;
        if (stb0 === 1'b1) begin
            stbCyc.push_back(cycleNo);
            stbPhone.push_back(phone0);
            stbLevel.push_back(level0);
        end
        checkOutput();
    endtask

    task automatic clearLog();
        stbCyc.delete();
        stbPhone.delete();
        stbLevel.delete();
    endtask

    task automatic drainIdle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!mBusy && (mq.size() == 0) && (busy0 === 1'b0) && (level0 === 4'd0)) begin
                ok = 1'b1;
                break;
            end
            applyStimulus(1'b0, 8'h00, 1'b0);
        end
        check({name, "_drain"}, ok, 1);
    endtask

    initial begin
        bit found;
        int busyCount;

        // directed table: one write of 8'h45, dur 3, CLK_DIV 4
        tbl[0] = '{we:1'b1, din:8'h45, dur:8'd3, stb:1'b0, busy:1'b0, phone:6'h3F, infl:2'd0, ar:1'b1, lvl:4'd1};
        tbl[1] = '{we:1'b0, din:8'h00, dur:8'd3, stb:1'b1, busy:1'b1, phone:6'h05, infl:2'd1, ar:1'b0, lvl:4'd0};
        for (int i = 2; i < 15; i++) begin
            tbl[i] = '{we:1'b0, din:8'h00, dur:8'd3, stb:1'b0, busy:1'b1, phone:6'h05, infl:2'd1, ar:1'b0, lvl:4'd0};
        end
        tbl[15] = '{we:1'b0, din:8'h00, dur:8'd3, stb:1'b0, busy:1'b0, phone:6'h05, infl:2'd1, ar:1'b0, lvl:4'd0};
        tbl[16] = '{we:1'b0, din:8'h00, dur:8'd3, stb:1'b0, busy:1'b0, phone:6'h05, infl:2'd1, ar:1'b1, lvl:4'd0};

        nVec    = 0;
        nBad    = 0;
        cycleNo = 0;
        reset_n = 1'b0;
        cpuWe   = 1'b0;
        ovfClr  = 1'b0;
        cpuDin  = 8'h00;
        durIn   = 8'h00;
`ifdef SPEECH_PHONE_QUEUE_FLUSH_EN
        flushIn = 1'b0;
`endif
        modelReset();
        repeat (3) @(negedge clk);

        check("rst_phone", phone0, 6'h3F);
        check("rst_infl", infl0, 2'd0);
        check("rst_stb", stb0, 1'b0);
        check("rst_busy", busy0, 1'b0);
        check("rst_ar0", ar0, 1'b1);
        check("rst_ar1", ar1, 1'b1);
        check("rst_level", level0, 4'd0);
        check("rst_ovf", ovf0, 1'b0);
        reset_n = 1'b1;

        $display("[TB] single phone table");
        for (int i = 0; i < 17; i++) begin
            durIn = tbl[i].dur;
            applyStimulus(tbl[i].we, tbl[i].din, 1'b0);
            check($sformatf("tbl%0d_stb", i), stb0, tbl[i].stb);
            check($sformatf("tbl%0d_busy", i), busy0, tbl[i].busy);
            check($sformatf("tbl%0d_phone", i), phone0, tbl[i].phone);
            check($sformatf("tbl%0d_infl", i), infl0, tbl[i].infl);
            check($sformatf("tbl%0d_ar", i), ar0, tbl[i].ar);
            check($sformatf("tbl%0d_level", i), level0, tbl[i].lvl);
        end

        $display("[TB] back-to-back phones");
        durIn = 8'd2;
        clearLog();
        applyStimulus(1'b1, 8'h01, 1'b0);
        applyStimulus(1'b1, 8'h02, 1'b0);
        applyStimulus(1'b1, 8'h03, 1'b0);
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 8'h00, 1'b0);
        check("b2b_count", stbCyc.size(), 3);
        if (stbCyc.size() == 3) begin
            check("b2b_phone0", stbPhone[0], 6'h01);
            check("b2b_phone1", stbPhone[1], 6'h02);
            check("b2b_phone2", stbPhone[2], 6'h03);
            check("b2b_gap1", stbCyc[1] - stbCyc[0], 10);
            check("b2b_gap2", stbCyc[2] - stbCyc[1], 10);
            check("b2b_level1", stbLevel[1], 4'd1);
            check("b2b_level2", stbLevel[2], 4'd0);
        end
        drainIdle("b2b");

        $display("[TB] overflow and full-queue pop");
        durIn = 8'd3;
        clearLog();
        applyStimulus(1'b1, 8'h20, 1'b0);
        for (int k = 1; k <= 9; k++) applyStimulus(1'b1, 8'(8'h20 + k), 1'b0);
        check("ovf_level", level0, 4'd8);
        check("ovf_set", ovf0, 1'b1);
        check("ovf_ar1_low", ar1, 1'b0);
        check("ovf_ar0_low", ar0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        check("ovf_clr", ovf0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mBusy && !mStop && (mT == mEnd)) begin
                found = 1'b1;
                break;
            end
            applyStimulus(1'b0, 8'h00, 1'b0);
        end
        check("ovf_done_reached", found, 1);
        applyStimulus(1'b1, 8'h2A, 1'b0);
        check("fullpop_level", level0, 4'd8);
        check("fullpop_ovf", ovf0, 1'b0);
        check("fullpop_stb", stb0, 1'b1);
        check("fullpop_phone", phone0, 6'h21);
        drainIdle("ovf");
        found = 1'b0;
        foreach (stbPhone[i]) if (stbPhone[i] == 6'h29) found = 1'b1;
        check("ninth_never_launched", found, 0);
        check("last_launched", stbPhone[stbPhone.size()-1], 6'h2A);

        $display("[TB] zero duration");
        durIn = 8'd0;
        busyCount = 0;
        applyStimulus(1'b1, 8'h07, 1'b0);
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            if (busy0 === 1'b1) busyCount++;
        end
        check("dur0_busy_cycles", busyCount, 6);

        $display("[TB] reset during play");
        durIn = 8'd3;
        applyStimulus(1'b1, 8'h11, 1'b0);
        applyStimulus(1'b1, 8'h12, 1'b0);
        applyStimulus(1'b1, 8'h13, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b0);
        check("pre_rst_busy", busy0, 1'b1);
        check("pre_rst_level", level0, 4'd2);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_phone", phone0, 6'h3F);
        check("arst_infl", infl0, 2'd0);
        check("arst_stb", stb0, 1'b0);
        check("arst_busy", busy0, 1'b0);
        check("arst_ar0", ar0, 1'b1);
        check("arst_ar1", ar1, 1'b1);
        check("arst_level", level0, 4'd0);
        check("arst_ovf", ovf0, 1'b0);
        modelReset();
        #20;
        reset_n = 1'b1;

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            durIn = 8'($urandom_range(0, 3));
`ifdef SPEECH_PHONE_QUEUE_FLUSH_EN
            flushIn = ($urandom_range(0, 99) == 0);
`endif
            applyStimulus($urandom_range(0, 99) < 35, 8'($urandom), $urandom_range(0, 19) == 0);
        end
        drainIdle("random");

`ifdef SPEECH_PHONE_QUEUE_FLUSH_EN
        $display("[TB] flush");
        applyStimulus(1'b0, 8'h00, 1'b1);
        durIn = 8'd3;
        applyStimulus(1'b1, 8'h30, 1'b0);
        for (int k = 1; k <= 5; k++) applyStimulus(1'b1, 8'(8'h30 + k), 1'b0);
        check("flush_pre_level", level0, 4'd5);
        clearLog();
        flushIn = 1'b1;
        applyStimulus(1'b1, 8'h3A, 1'b0);
        check("flush_level", level0, 4'd0);
        check("flush_stb", stb0, 1'b1);
        check("flush_phone", phone0, 6'h3F);
        check("flush_infl", infl0, 2'd0);
        check("flush_ovf", ovf0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        check("flush_idle", busy0, 1'b0);
        check("flush_stb_once", stb0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b0);
        check("flush_write_discarded", stbCyc.size(), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
